// File: rtl/rat_ckpt.sv
// Register alias table mapping architectural registers to ROB tags, with
// per-branch full-table checkpoints restored on mispredict.
module rat_ckpt #(
  parameter int ARCH_REGS = 32,
  parameter int ROB_DEPTH = 16,
  parameter int RD_PORTS  = 3,
  parameter int CKPT_NUM  = 4,
  parameter int AW        = $clog2(ARCH_REGS),
  parameter int TW        = $clog2(ROB_DEPTH),
  parameter int CW        = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RD_PORTS*AW-1:0] rd_addr,
  output logic [RD_PORTS-1:0]    rd_valid,
  output logic [RD_PORTS*TW-1:0] rd_paddr,
  input  logic                   alloc_en,
  input  logic                   alloc_dst_wen,
  input  logic [AW-1:0]          alloc_dst_addr,
  input  logic [TW-1:0]          alloc_tag,
  input  logic                   ckpt_take,
  output logic [CW-1:0]          ckpt_take_id,
  output logic                   ckpt_full,
  input  logic                   commit_en,
  input  logic [AW-1:0]          commit_dst_addr,
  input  logic [TW-1:0]          commit_tag,
  input  logic                   br_resolve_en,
  input  logic [CW-1:0]          br_resolve_id,
  input  logic                   br_mispredict,
  input  logic                   flush
);

  typedef logic [ARCH_REGS-1:0]         vmap_t;
  typedef logic [ARCH_REGS-1:0][TW-1:0] pmap_t;

  vmap_t                              valid_q, valid_d;
  pmap_t                              paddr_q, paddr_d;
  vmap_t [CKPT_NUM-1:0]               cv_q, cv_d;
  pmap_t [CKPT_NUM-1:0]               cp_q, cp_d;
  logic  [CKPT_NUM-1:0]               slot_valid_q, slot_valid_d;
  logic  [CKPT_NUM-1:0][CKPT_NUM-1:0] yng_q, yng_d;

  logic                restore, good_res, take, wr, commit_hit;
  logic [CKPT_NUM-1:0] kill;

  always_comb begin
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      rd_valid[p] = (rd_addr[p*AW +: AW] != '0) && valid_q[rd_addr[p*AW +: AW]];
      rd_paddr[p*TW +: TW] = (rd_addr[p*AW +: AW] != '0) ? paddr_q[rd_addr[p*AW +: AW]] : '0;
    end
  end

  assign ckpt_full = &slot_valid_q;

  always_comb begin
    ckpt_take_id = '0;
    for (int unsigned k = CKPT_NUM; k > 0; k--) begin
      if (!slot_valid_q[k-1]) ckpt_take_id = CW'(k-1);
    end
  end

  always_comb begin
    restore    = br_resolve_en && br_mispredict && slot_valid_q[br_resolve_id];
    good_res   = br_resolve_en && !br_mispredict && slot_valid_q[br_resolve_id];
    take       = alloc_en && ckpt_take && !ckpt_full && !restore;
    wr         = alloc_en && alloc_dst_wen && (alloc_dst_addr != '0) && !restore;
    commit_hit = commit_en && (commit_dst_addr != '0);

    // The restore source goes through the same commit/alloc path as the live
    // table, so the snapshot is scrubbed by this cycle's commit.
    valid_d = restore ? cv_q[br_resolve_id] : valid_q;
    paddr_d = restore ? cp_q[br_resolve_id] : paddr_q;
    if (commit_hit && paddr_d[commit_dst_addr] == commit_tag) begin
      valid_d[commit_dst_addr] = 1'b0;
      paddr_d[commit_dst_addr] = '0;
    end
    if (wr) begin
      valid_d[alloc_dst_addr] = 1'b1;
      paddr_d[alloc_dst_addr] = alloc_tag;
    end

    cv_d = cv_q;
    cp_d = cp_q;
    for (int unsigned k = 0; k < CKPT_NUM; k++) begin
      if (commit_hit && cp_q[k][commit_dst_addr] == commit_tag) begin
        cv_d[k][commit_dst_addr] = 1'b0;
        cp_d[k][commit_dst_addr] = '0;
      end
    end

    slot_valid_d = slot_valid_q;
    yng_d        = yng_q;
    kill         = '0;

    if (take) begin
      cv_d[ckpt_take_id]         = valid_d;
      cp_d[ckpt_take_id]         = paddr_d;
      slot_valid_d[ckpt_take_id] = 1'b1;
      for (int unsigned j = 0; j < CKPT_NUM; j++) begin
        if (slot_valid_q[j]) yng_d[j][ckpt_take_id] = 1'b1;
      end
      yng_d[ckpt_take_id] = '0;
    end

    if (good_res) begin
      slot_valid_d[br_resolve_id] = 1'b0;
      for (int unsigned j = 0; j < CKPT_NUM; j++) yng_d[j][br_resolve_id] = 1'b0;
    end

    if (restore) begin
      kill                = yng_q[br_resolve_id];
      kill[br_resolve_id] = 1'b1;
      for (int unsigned k = 0; k < CKPT_NUM; k++) begin
        if (kill[k]) begin
          slot_valid_d[k] = 1'b0;
          yng_d[k]        = '0;
          for (int unsigned j = 0; j < CKPT_NUM; j++) yng_d[j][k] = 1'b0;
        end
      end
    end

    if (flush) begin
      valid_d      = '0;
      paddr_d      = '0;
      cv_d         = cv_q;
      cp_d         = cp_q;
      slot_valid_d = '0;
      yng_d        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      paddr_q      <= '0;
      cv_q         <= '0;
      cp_q         <= '0;
      slot_valid_q <= '0;
      yng_q        <= '0;
    end else begin
      valid_q      <= valid_d;
      paddr_q      <= paddr_d;
      cv_q         <= cv_d;
      cp_q         <= cp_d;
      slot_valid_q <= slot_valid_d;
      yng_q        <= yng_d;
    end
  end

endmodule
